// File: rtl/score_ctrl_if.sv
// ---------------------------------------------------------------------------
// score_ctrl_if : button/counter/strobe bundle between the game controller
//                 and its environment
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface score_ctrl_if #(
  parameter int BW = 7
);
  logic          start;
  logic          clr;
  logic [3:0]    btn;
  logic [BW-1:0] cnt_a;
  logic [BW-1:0] cnt_b;
  logic          up_a;
  logic          down_a;
  logic          up_b;
  logic          down_b;
  logic          cnt_rst;
  logic [1:0]    state;
  logic [1:0]    winner;

  modport master (
    output start, clr, btn, cnt_a, cnt_b,
    input  up_a, down_a, up_b, down_b, cnt_rst, state, winner
  );

  modport slave (
    input  start, clr, btn, cnt_a, cnt_b,
    output up_a, down_a, up_b, down_b, cnt_rst, state, winner
  );
endinterface

`default_nettype wire

// File: rtl/score_ctrl.sv
// ---------------------------------------------------------------------------
// score_ctrl : debounced scoreboard buttons, round-robin strobe arbiter and
//              IDLE/RUN/WON/CLEAR game FSM driving two score counters
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module score_ctrl #(
  parameter int BW        = 7,
  parameter int MAX_SCORE = 99,
  parameter int WIN_SCORE = 21,
  parameter int DB_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  score_ctrl_if.slave bus
);

  localparam int DBW = $clog2(DB_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    WON   = 2'b10,
    CLEAR = 2'b11
  } state_t;

  state_t     state;
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] db_level;
  logic [3:0] db_prev;
  logic [3:0] rise;
  logic [3:0] pending;
  logic [1:0] start_sync;
  logic [1:0] clr_sync;
  logic [1:0] ptr;
  logic [3:0] strobe;
  logic       cnt_rst;
  logic [1:0] winner;
  logic       clear_cnt;

  logic       win_a;
  logic       win_b;
  logic       found;
  logic       drop;
  logic       decide;
  logic [1:0] grant;
  logic [1:0] idx;
  logic [3:0] grant_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= '0;
      sync2      <= '0;
      db_prev    <= '0;
      start_sync <= '0;
      clr_sync   <= '0;
    end else begin
      sync1      <= bus.btn;
      sync2      <= sync1;
      db_prev    <= db_level;
      start_sync <= {start_sync[0], bus.start};
      clr_sync   <= {clr_sync[0], bus.clr};
    end
  end

  // The level follows the synchronised input only after it has differed for DB_CYCLES cycles.
  for (genvar n = 0; n < 4; n++) begin : g_btn
    logic [DBW-1:0] cnt;
    logic           level;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt   <= '0;
        level <= 1'b0;
      end else if (sync2[n] == level) begin
        cnt <= '0;
      end else if (cnt == DBW'(DB_CYCLES - 1)) begin
        level <= sync2[n];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign db_level[n] = level;
  end

  assign rise  = db_level & ~db_prev;
  assign win_a = (bus.cnt_a >= BW'(WIN_SCORE));
  assign win_b = (bus.cnt_b >= BW'(WIN_SCORE));

  always_comb begin
    found = 1'b0;
    grant = ptr;
    idx   = ptr;
    // Scan downwards so the request nearest the pointer is the one left in grant.
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (pending[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  always_comb begin
    drop = 1'b0;
    case (grant)
      2'd0:    drop = (bus.cnt_a == BW'(MAX_SCORE));
      2'd1:    drop = (bus.cnt_a == '0);
      2'd2:    drop = (bus.cnt_b == BW'(MAX_SCORE));
      default: drop = (bus.cnt_b == '0);
    endcase
  end

  // No decision while a strobe is high, so every strobe is followed by a low cycle.
  assign decide     = (state == RUN) && !win_a && !win_b && (strobe == '0) && found;
  assign grant_mask = decide ? (4'b0001 << grant) : 4'b0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt_rst   <= 1'b1;
      winner    <= 2'b00;
      clear_cnt <= 1'b0;
      pending   <= '0;
      ptr       <= '0;
      strobe    <= '0;
    end else begin
      strobe <= '0;
      case (state)
        IDLE: begin
          cnt_rst <= 1'b1;
          winner  <= 2'b00;
          pending <= '0;
          if (start_sync[1]) begin
            state   <= RUN;
            cnt_rst <= 1'b0;
          end
        end
        RUN: begin
          cnt_rst <= 1'b0;
          if (win_a || win_b) begin
            state   <= WON;
            winner  <= win_a ? 2'b01 : 2'b10;
            pending <= '0;
          end else begin
            pending <= (pending & ~grant_mask) | rise;
            if (decide) begin
              ptr <= grant + 2'd1;
              if (!drop) begin
                strobe <= grant_mask;
              end
            end
          end
        end
        WON: begin
          pending <= '0;
          if (clr_sync[1]) begin
            state     <= CLEAR;
            cnt_rst   <= 1'b1;
            winner    <= 2'b00;
            clear_cnt <= 1'b0;
          end
        end
        default: begin
          cnt_rst   <= 1'b1;
          winner    <= 2'b00;
          pending   <= '0;
          clear_cnt <= 1'b1;
          if (clear_cnt) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.up_a    = strobe[0];
  assign bus.down_a  = strobe[1];
  assign bus.up_b    = strobe[2];
  assign bus.down_b  = strobe[3];
  assign bus.cnt_rst = cnt_rst;
  assign bus.state   = state;
  assign bus.winner  = winner;

endmodule

`default_nettype wire

// File: tb/tb_score_ctrl.sv
// ---------------------------------------------------------------------------
// tb_score_ctrl : randomized self-checking bench for score_ctrl
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_score_ctrl;

  localparam int BW   = 7;
  localparam int MAXS = 99;
  localparam int WINS = 21;
  localparam int DB   = 4;
  // Press-to-strobe delay: two sync stages, DB debounce cycles, pending, strobe register.
  localparam int LAT  = 2 + DB + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  score_ctrl_if #(.BW(BW)) bus ();

  score_ctrl #(
    .BW(BW), .MAX_SCORE(MAXS), .WIN_SCORE(WINS), .DB_CYCLES(DB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;
  int obs_id[$];
  int obs_cyc[$];
  int multi;

  initial begin
    #200us;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  task automatic collect(input int first_k, input int n);
    logic [3:0] v;
    obs_id.delete();
    obs_cyc.delete();
    multi = 0;
    for (int k = first_k; k < first_k + n; k++) begin
      @(negedge clk);
      v = {bus.down_b, bus.up_b, bus.down_a, bus.up_a};
      if ($countones(v) > 1) multi++;
      for (int b = 0; b < 4; b++) begin
        if (v[b]) begin
          obs_id.push_back(b);
          obs_cyc.push_back(k);
        end
      end
    end
  endtask

  task automatic go_run(output bit ok);
    ok = 1'b0;
    bus.start = 1'b1;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (bus.state == 2'b01) ok = 1'b1;
    end
    bus.start = 1'b0;
  endtask

  task automatic release_btns;
    bus.btn = 4'b0000;
    repeat (12) @(negedge clk);
  endtask

  task automatic wait_state(input logic [1:0] s, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.state == s) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.clr = 1'b0; bus.btn = 4'b0000;
    bus.cnt_a = '0;   bus.cnt_b = '0;
    repeat (10) @(negedge clk);
    checks++;
    if (bus.state !== 2'b00 || bus.cnt_rst !== 1'b1 || bus.winner !== 2'b00 ||
        {bus.up_a, bus.down_a, bus.up_b, bus.down_b} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_values state=%b cnt_rst=%b winner=%b strobes=%b exp 00/1/00/0000",
               bus.state, bus.cnt_rst, bus.winner, {bus.up_a, bus.down_a, bus.up_b, bus.down_b});
    end
    rst_n = 1'b1;
    m_ptr = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.state !== 2'b00 || bus.cnt_rst !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_reset state=%b cnt_rst=%b exp 00/1", bus.state, bus.cnt_rst);
    end
  endtask

  task automatic test_arbitration;
    for (int it = 0; it < 8; it++) begin
      logic [3:0] mask;
      int ca, cb, d, last;
      int exp_id[$];
      int exp_cyc[$];
      bit ok;
      exp_id.delete();
      exp_cyc.delete();
      if (it == 0) begin
        mask = 4'hF; ca = 10; cb = 10;
      end else begin
        mask = 4'($urandom_range(1, 15));
        ca = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, WINS - 1));
        cb = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, WINS - 1));
      end
      go_run(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL arb_run_entry iter=%0d state=%b exp 01", it, bus.state);
      end
      bus.cnt_a = BW'(ca);
      bus.cnt_b = BW'(cb);
      // Requests are served in cyclic order from the pointer; drops take one cycle, strobes two.
      d = LAT - 1;
      last = m_ptr;
      for (int s = 0; s < 4; s++) begin
        int i;
        i = (m_ptr + s) % 4;
        if (mask[i]) begin
          if ((i == 0 && ca == MAXS) || (i == 1 && ca == 0) ||
              (i == 2 && cb == MAXS) || (i == 3 && cb == 0)) begin
            d += 1;
          end else begin
            exp_id.push_back(i);
            exp_cyc.push_back(d + 1);
            d += 2;
          end
          last = i;
        end
      end
      m_ptr = (last + 1) % 4;
      bus.btn = mask;
      collect(1, 20);
      checks++;
      if (obs_id.size() != exp_id.size() || multi != 0) begin
        errors++;
        $display("FAIL arb_count iter=%0d mask=%b ca=%0d cb=%0d got=%0d exp=%0d overlap=%0d",
                 it, mask, ca, cb, obs_id.size(), exp_id.size(), multi);
      end
      for (int j = 0; j < exp_id.size() && j < obs_id.size(); j++) begin
        checks++;
        if (obs_id[j] != exp_id[j] || obs_cyc[j] != exp_cyc[j]) begin
          errors++;
          $display("FAIL arb_order iter=%0d n=%0d got id%0d@%0d exp id%0d@%0d",
                   it, j, obs_id[j], obs_cyc[j], exp_id[j], exp_cyc[j]);
        end
      end
      release_btns();
    end
  endtask

  task automatic test_single_press;
    bit ok;
    go_run(ok);
    bus.cnt_a = 7'd5;
    bus.cnt_b = 7'd2;
    bus.btn = 4'b0001;
    collect(1, 20);
    m_ptr = 1;
    checks++;
    if (!ok || obs_id.size() != 1 || obs_id[0] != 0 || obs_cyc[0] != LAT) begin
      errors++;
      $display("FAIL single_press pulses=%0d first_id=%0d first_cycle=%0d exp 1 pulse id0 at %0d",
               obs_id.size(), (obs_id.size() > 0) ? obs_id[0] : -1,
               (obs_cyc.size() > 0) ? obs_cyc[0] : -1, LAT);
    end
    release_btns();
  endtask

  task automatic test_bounce;
    bit ok;
    go_run(ok);
    bus.cnt_b = BW'($urandom_range(0, WINS - 1));
    bus.btn = 4'b0100;
    @(negedge clk);
    bus.btn = 4'b0000;
    @(negedge clk);
    bus.btn = 4'b0100;
    collect(3, 22);
    m_ptr = 3;
    checks++;
    if (!ok || obs_id.size() != 1 || obs_id[0] != 2 || obs_cyc[0] != LAT + 2) begin
      errors++;
      $display("FAIL bounce pulses=%0d first_id=%0d first_cycle=%0d exp 1 pulse id2 at %0d",
               obs_id.size(), (obs_id.size() > 0) ? obs_id[0] : -1,
               (obs_cyc.size() > 0) ? obs_cyc[0] : -1, LAT + 2);
    end
    release_btns();
  endtask

  task automatic test_limits;
    bit ok;
    go_run(ok);
    bus.cnt_a = 7'd0;
    bus.cnt_b = 7'd7;
    bus.btn = 4'b0010;
    collect(1, 20);
    m_ptr = 2;
    checks++;
    if (obs_id.size() != 0) begin
      errors++;
      $display("FAIL limit_down_a pulses=%0d exp 0", obs_id.size());
    end
    release_btns();
    bus.btn = 4'b0001;
    collect(1, 20);
    m_ptr = 1;
    checks++;
    if (obs_id.size() != 1 || obs_id[0] != 0 || obs_cyc[0] != LAT) begin
      errors++;
      $display("FAIL limit_next_press pulses=%0d first_cycle=%0d exp 1 at %0d",
               obs_id.size(), (obs_cyc.size() > 0) ? obs_cyc[0] : -1, LAT);
    end
    release_btns();
    bus.cnt_b = 7'(MAXS);
    bus.btn = 4'b0100;
    collect(1, 20);
    checks++;
    if (obs_id.size() != 0 || bus.state !== 2'b10) begin
      errors++;
      $display("FAIL limit_up_b pulses=%0d state=%b exp 0 pulses state 10", obs_id.size(), bus.state);
    end
    release_btns();
    bus.cnt_b = 7'd0;
    bus.clr = 1'b1;
    wait_state(2'b00, ok);
    bus.clr = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL limit_back_idle state=%b exp 00", bus.state);
    end
  endtask

  task automatic test_game_flow;
    bit ok;
    go_run(ok);
    bus.cnt_a = 7'd3;
    bus.cnt_b = 7'(WINS);
    wait_state(2'b10, ok);
    checks++;
    if (!ok || bus.winner !== 2'b10) begin
      errors++;
      $display("FAIL win_b state=%b winner=%b exp 10/10", bus.state, bus.winner);
    end
    bus.btn = 4'hF;
    collect(1, 15);
    checks++;
    if (obs_id.size() != 0 || bus.winner !== 2'b10 || bus.state !== 2'b10) begin
      errors++;
      $display("FAIL won_ignores_btn pulses=%0d winner=%b state=%b exp 0/10/10",
               obs_id.size(), bus.winner, bus.state);
    end
    release_btns();
    bus.cnt_a = '0;
    bus.cnt_b = '0;
    bus.clr = 1'b1;
    wait_state(2'b11, ok);
    checks++;
    if (!ok || bus.cnt_rst !== 1'b1 || bus.winner !== 2'b00) begin
      errors++;
      $display("FAIL clear_entry state=%b cnt_rst=%b winner=%b exp 11/1/00", bus.state, bus.cnt_rst, bus.winner);
    end
    @(negedge clk);
    checks++;
    if (bus.state !== 2'b11 || bus.cnt_rst !== 1'b1) begin
      errors++;
      $display("FAIL clear_second state=%b cnt_rst=%b exp 11/1", bus.state, bus.cnt_rst);
    end
    @(negedge clk);
    bus.clr = 1'b0;
    checks++;
    if (bus.state !== 2'b00 || bus.cnt_rst !== 1'b1) begin
      errors++;
      $display("FAIL clear_to_idle state=%b cnt_rst=%b exp 00/1", bus.state, bus.cnt_rst);
    end
    repeat (3) @(negedge clk);
    go_run(ok);
    bus.cnt_a = 7'(WINS);
    bus.cnt_b = 7'(WINS + 5);
    wait_state(2'b10, ok);
    checks++;
    if (!ok || bus.winner !== 2'b01) begin
      errors++;
      $display("FAIL win_a_priority state=%b winner=%b exp 10/01", bus.state, bus.winner);
    end
    bus.cnt_a = '0;
    bus.cnt_b = '0;
    bus.clr = 1'b1;
    wait_state(2'b00, ok);
    bus.clr = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_strobe;
    bit ok, seen;
    go_run(ok);
    bus.cnt_a = 7'd4;
    bus.cnt_b = 7'd1;
    bus.btn = 4'b0001;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.up_a === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL mid_strobe_seen up_a=%b exp 1 within 20 cycles", bus.up_a);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.up_a !== 1'b0 || bus.state !== 2'b00 || bus.cnt_rst !== 1'b1) begin
      errors++;
      $display("FAIL async_abort up_a=%b state=%b cnt_rst=%b exp 0/00/1", bus.up_a, bus.state, bus.cnt_rst);
    end
    bus.btn = 4'b0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_single_press();
    test_bounce();
    test_limits();
    test_game_flow();
    test_reset_mid_strobe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
